// File: rtl/az_lsp_poly_pkg.sv
// Shared constants and state encoding for the A(z) -> F1/F2 polynomial block.
// Optional feature macro: AZ_LSP_POLY_OVF_EN (sticky overflow output).
package az_lsp_poly_pkg;

    localparam int M      = 10;   // LPC order
    localparam int NC     = 5;    // number of F1/F2 coefficients beyond index 0
    localparam int ADDR_W = 12;   // scratch-memory address width
    localparam int DATA_W = 16;   // coefficient width

    localparam logic [DATA_W-1:0] F_INIT = 16'h0800;  // 1.0 in Q11

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ1 = 3'd1,
        READ2 = 3'd2,
        CALC  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/az_lsp_poly_sat_addsub16.sv
// 16-bit add/subtract evaluated at 17 bits and saturated back to 16 bits.
// Matches G.729 add()/sub(); clip_o flags any saturation.
module sat_addsub16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [15:0] y_o,
    output logic        clip_o
);

    logic signed [16:0] a_ext;
    logic signed [16:0] b_ext;
    logic signed [16:0] r;

    // Full-precision result, then clamp when the top two bits disagree
    always_comb begin
        a_ext  = signed'({a_i[15], a_i});
        b_ext  = signed'({b_i[15], b_i});
        r      = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
        clip_o = r[16] ^ r[15];
        if (clip_o) begin
            y_o = r[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            y_o = r[15:0];
        end
    end

endmodule

// File: rtl/az_lsp_poly.sv
// Builds the symmetric/antisymmetric LSP polynomials F1(z), F2(z) from the
// LPC array a[0..10] held in scratch memory. Each of the 5 iterations reads
// a[i+1] and a[10-i] (one-cycle read latency) and updates one F1 and one F2
// coefficient. Optional: define AZ_LSP_POLY_OVF_EN for a sticky overflow flag.
module az_lsp_poly
    import az_lsp_poly_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    input  logic [ADDR_W-1:0] aBase,
    output logic [ADDR_W-1:0] memReadAddr,
    input  logic [DATA_W-1:0] memIn,
    output logic [DATA_W-1:0] f1_0,
    output logic [DATA_W-1:0] f1_1,
    output logic [DATA_W-1:0] f1_2,
    output logic [DATA_W-1:0] f1_3,
    output logic [DATA_W-1:0] f1_4,
    output logic [DATA_W-1:0] f1_5,
    output logic [DATA_W-1:0] f2_0,
    output logic [DATA_W-1:0] f2_1,
    output logic [DATA_W-1:0] f2_2,
    output logic [DATA_W-1:0] f2_3,
    output logic [DATA_W-1:0] f2_4,
    output logic [DATA_W-1:0] f2_5
`ifdef AZ_LSP_POLY_OVF_EN
    ,
    output logic              overflow
`endif
);

    state_t             state_q, state_d;
    logic [2:0]         i_q, i_d;
    logic [DATA_W-1:0]  ahi_q;            // a[i+1], captured in READ2
    logic [DATA_W-1:0]  f1_q [0:NC];
    logic [DATA_W-1:0]  f2_q [0:NC];
    logic               start_acc;
    logic               calc_en;

    logic signed [16:0] sum17;
    logic signed [16:0] dif17;
    logic [DATA_W-1:0]  x1;
    logic [DATA_W-1:0]  x2;
    logic [DATA_W-1:0]  f1_new;
    logic [DATA_W-1:0]  f2_new;
    logic               clip1;
    logic               clip2;

    // State and loop-index register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
        end
    end

    // Next state, read address and done pulse
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        memReadAddr = '0;
        done        = 1'b0;
        start_acc   = 1'b0;
        calc_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    i_d       = 3'd0;
                    state_d   = READ1;
                end
            end
            READ1: begin
                memReadAddr = aBase + ADDR_W'(i_q) + ADDR_W'(1);
                state_d     = READ2;
            end
            READ2: begin
                memReadAddr = aBase + ADDR_W'(M) - ADDR_W'(i_q);
                state_d     = CALC;
            end
            CALC: begin
                calc_en = 1'b1;
                if (i_q == 3'(NC - 1)) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 3'd1;
                    state_d = READ1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pair terms: (a[i+1] +/- a[10-i]) >>> 2 at 17 bits, result fits in 16
    always_comb begin
        sum17 = signed'({ahi_q[15], ahi_q}) + signed'({memIn[15], memIn});
        dif17 = signed'({ahi_q[15], ahi_q}) - signed'({memIn[15], memIn});
        x1    = {sum17[16], sum17[16:2]};
        x2    = {dif17[16], dif17[16:2]};
    end

    sat_addsub16 u_sat_f1 (
        .a_i    (x1),
        .b_i    (f1_q[i_q]),
        .sub_i  (1'b1),
        .y_o    (f1_new),
        .clip_o (clip1)
    );

    sat_addsub16 u_sat_f2 (
        .a_i    (x2),
        .b_i    (f2_q[i_q]),
        .sub_i  (1'b0),
        .y_o    (f2_new),
        .clip_o (clip2)
    );

    // Coefficient registers and a[i+1] holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            ahi_q <= '0;
            for (int k = 0; k <= NC; k++) begin
                f1_q[k] <= (k == 0) ? F_INIT : '0;
                f2_q[k] <= (k == 0) ? F_INIT : '0;
            end
        end else begin
            if (start_acc) begin
                f1_q[0] <= F_INIT;
                f2_q[0] <= F_INIT;
            end
            if (state_q == READ2) begin
                ahi_q <= memIn;
            end
            if (calc_en) begin
                f1_q[i_q + 3'd1] <= f1_new;
                f2_q[i_q + 3'd1] <= f2_new;
            end
        end
    end

`ifdef AZ_LSP_POLY_OVF_EN
    logic ovf_q;

    // Sticky saturation flag, cleared by reset or an accepted start
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            ovf_q <= 1'b0;
        end else if (calc_en && (clip1 || clip2)) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_clip;
    assign unused_clip = clip1 ^ clip2;
`endif

    assign f1_0 = f1_q[0];
    assign f1_1 = f1_q[1];
    assign f1_2 = f1_q[2];
    assign f1_3 = f1_q[3];
    assign f1_4 = f1_q[4];
    assign f1_5 = f1_q[5];
    assign f2_0 = f2_q[0];
    assign f2_1 = f2_q[1];
    assign f2_2 = f2_q[2];
    assign f2_3 = f2_q[3];
    assign f2_4 = f2_q[4];
    assign f2_5 = f2_q[5];

endmodule

// File: tb/tb_az_lsp_poly.sv
// Directed, table-driven bench for az_lsp_poly with a one-cycle-latency
// scratch-memory model. Honours AZ_LSP_POLY_OVF_EN when defined.
module tb_az_lsp_poly;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [11:0] aBase;
    logic [11:0] memReadAddr;
    logic [15:0] memIn;
    logic [15:0] f1_0, f1_1, f1_2, f1_3, f1_4, f1_5;
    logic [15:0] f2_0, f2_1, f2_2, f2_3, f2_4, f2_5;
`ifdef AZ_LSP_POLY_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:4095];

    typedef struct packed {
        logic [11:0]        base;
        logic [10:1][15:0]  a;
        logic [5:0][15:0]   ef1;
        logic [5:0][15:0]   ef2;
        logic               eovf;
    } vec_t;

    vec_t vecs [4];

    az_lsp_poly dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .aBase       (aBase),
        .memReadAddr (memReadAddr),
        .memIn       (memIn),
        .f1_0        (f1_0),
        .f1_1        (f1_1),
        .f1_2        (f1_2),
        .f1_3        (f1_3),
        .f1_4        (f1_4),
        .f1_5        (f1_5),
        .f2_0        (f2_0),
        .f2_1        (f2_1),
        .f2_2        (f2_2),
        .f2_3        (f2_3),
        .f2_4        (f2_4),
        .f2_5        (f2_5)
`ifdef AZ_LSP_POLY_OVF_EN
        ,
        .overflow    (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Scratch memory: data valid one cycle after the address
    always @(posedge clk) memIn <= mem[memReadAddr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] get_f1(input int k);
        case (k)
            0: return f1_0;
            1: return f1_1;
            2: return f1_2;
            3: return f1_3;
            4: return f1_4;
            default: return f1_5;
        endcase
    endfunction

    function automatic logic [15:0] get_f2(input int k);
        case (k)
            0: return f2_0;
            1: return f2_1;
            2: return f2_2;
            3: return f2_3;
            4: return f2_4;
            default: return f2_5;
        endcase
    endfunction

    task automatic load_mem(input int v);
        logic [11:0] ad;
        for (int n = 0; n < 4096; n++) mem[n] = 16'hDEAD;
        for (int k = 1; k <= 10; k++) begin
            ad = vecs[v].base + 12'(k);
            mem[ad] = vecs[v].a[k];
        end
        aBase = vecs[v].base;
    endtask

    task automatic check_outputs(input int v);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("v%0d f1_%0d", v, k), 32'(get_f1(k)), 32'(vecs[v].ef1[k]));
            chk($sformatf("v%0d f2_%0d", v, k), 32'(get_f2(k)), 32'(vecs[v].ef2[k]));
        end
`ifdef AZ_LSP_POLY_OVF_EN
        chk($sformatf("v%0d overflow", v), 32'(ovf), 32'(vecs[v].eovf));
`endif
    endtask

    // One run: start sampled at edge 0, then cycles 1..20 observed at negedge
    task automatic run_vec(input int v);
        int          done_cnt;
        int          done_cyc;
        int          addr_bad;
        logic [11:0] exp_addr;
        int          it;
        int          ph;
        load_mem(v);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done_cnt = 0;
        done_cyc = -1;
        addr_bad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            it = (c - 1) / 3;
            ph = (c - 1) % 3;
            if (c <= 15 && ph == 0)      exp_addr = vecs[v].base + 12'(it + 1);
            else if (c <= 15 && ph == 1) exp_addr = vecs[v].base + 12'(10 - it);
            else                         exp_addr = 12'h000;
            if (memReadAddr !== exp_addr) begin
                if (addr_bad == 0)
                    $display("note v%0d cycle %0d addr %0h expected %0h", v, c, memReadAddr, exp_addr);
                addr_bad++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        chk($sformatf("v%0d addr_seq_errs", v), 32'(addr_bad), 32'd0);
        chk($sformatf("v%0d done_cycle", v), 32'(done_cyc), 32'd16);
        chk($sformatf("v%0d done_count", v), 32'(done_cnt), 32'd1);
        check_outputs(v);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        aBase = 12'h000;
        for (int n = 0; n < 4096; n++) mem[n] = 16'h0000;

        // Vector table: base, a[1..10], expected f1[5:0], f2[5:0], overflow
        vecs[0].base = 12'h100;
        vecs[0].a    = '0;
        vecs[0].ef1  = {16'hF800, 16'h0800, 16'hF800, 16'h0800, 16'hF800, 16'h0800};
        vecs[0].ef2  = {6{16'h0800}};
        vecs[0].eovf = 1'b0;

        vecs[1].base  = 12'h200;
        vecs[1].a     = '0;
        vecs[1].a[1]  = 16'h4000;
        vecs[1].a[10] = 16'h4000;
        vecs[1].ef1   = {16'h1800, 16'hE800, 16'h1800, 16'hE800, 16'h1800, 16'h0800};
        vecs[1].ef2   = {6{16'h0800}};
        vecs[1].eovf  = 1'b0;

        vecs[2].base = 12'hFFA;
        for (int k = 1; k <= 5; k++)  vecs[2].a[k] = 16'h7FFF;
        for (int k = 6; k <= 10; k++) vecs[2].a[k] = 16'h8000;
        vecs[2].ef1  = {16'hF7FF, 16'h0800, 16'hF7FF, 16'h0800, 16'hF7FF, 16'h0800};
        vecs[2].ef2  = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h47FF, 16'h0800};
        vecs[2].eovf = 1'b1;

        vecs[3].base  = 12'h7F0;
        vecs[3].a     = '0;
        vecs[3].a[1]  = 16'h0100;
        vecs[3].a[10] = 16'h0200;
        vecs[3].a[2]  = 16'h0040;
        vecs[3].a[9]  = 16'hFFC0;
        vecs[3].a[5]  = 16'h0010;
        vecs[3].a[6]  = 16'h0013;
        vecs[3].ef1   = {16'hF8C8, 16'h0740, 16'hF8C0, 16'h0740, 16'hF8C0, 16'h0800};
        vecs[3].ef2   = {16'h07DF, 16'h07E0, 16'h07E0, 16'h07E0, 16'h07C0, 16'h0800};
        vecs[3].eovf  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        chk("rst done", 32'(done), 32'd0);
        chk("rst addr", 32'(memReadAddr), 32'd0);
        chk("rst f1_0", 32'(f1_0), 32'h0800);
        chk("rst f2_0", 32'(f2_0), 32'h0800);
        chk("rst f1_3", 32'(f1_3), 32'h0000);
        chk("rst f2_5", 32'(f2_5), 32'h0000);
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;

        for (int v = 0; v < 4; v++) run_vec(v);

        // Outputs hold after completion while idle
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("hold f1_5", 32'(f1_5), 32'(vecs[3].ef1[5]));
        chk("hold f2_1", 32'(f2_1), 32'(vecs[3].ef2[1]));

        // Abort by reset in cycle 7 of a run, then a clean run
        begin
            int dn;
            int abad;
            load_mem(1);
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            dn = 0;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                if (done === 1'b1) dn++;
                @(posedge clk); #1;
            end
            chk("abort f1_1 pre", 32'(f1_1), 32'h1800);
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            abad = 0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (done === 1'b1) dn++;
                if (memReadAddr !== 12'h000) abad++;
            end
            chk("abort done_count", 32'(dn), 32'd0);
            chk("abort idle_addr", 32'(abad), 32'd0);
            chk("abort f1_0", 32'(f1_0), 32'h0800);
            chk("abort f1_1", 32'(f1_1), 32'h0000);
            chk("abort f2_1", 32'(f2_1), 32'h0000);
            run_vec(1);
        end

        // Start level held across done: two back-to-back runs 17 cycles apart
        begin
            int dn;
            int d1;
            int d2;
            load_mem(0);
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1;
            dn = 0;
            d1 = -1;
            d2 = -1;
            for (int c = 1; c <= 45; c++) begin
                start = (c == 5 || c == 6 || c == 15 || c == 16 || c == 17 || c == 25);
                @(negedge clk);
                if (done === 1'b1) begin
                    dn++;
                    if (d1 < 0) d1 = c;
                    else if (d2 < 0) d2 = c;
                end
                @(posedge clk); #1;
            end
            start = 1'b0;
            chk("b2b done_count", 32'(dn), 32'd2);
            chk("b2b first_done", 32'(d1), 32'd16);
            chk("b2b gap", 32'(d2 - d1), 32'd17);
            chk("b2b f1_5", 32'(f1_5), 32'hF800);
            chk("b2b f2_3", 32'(f2_3), 32'h0800);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
